// File: rtl/computie_bus_target.sv
// computie_bus_target: bridges asynchronous bus strobes to a registered valid/ready device request with wait states and timeout.
module computie_bus_target #(
    parameter int BITWIDTH = 32,
    parameter logic [BITWIDTH-1:0] BASE_ADDR = 32'h0010_0000,
    parameter logic [BITWIDTH-1:0] ADDR_MASK = 32'hFFF0_0000,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                addr_strobe,
    input  logic                data_strobe,
    input  logic                read_write,
    input  logic [BITWIDTH-1:0] from_bus,
    output logic [BITWIDTH-1:0] to_bus,
    output logic                demux_oe,
    output logic                addr_oe,
    output logic                data_oe,
    output logic                data_dir,
    output logic                send_receive,
    output logic                data_ack_n,
    output logic                bus_err_n,
    output logic                req_valid,
    output logic                req_write,
    output logic [BITWIDTH-1:0] req_addr,
    output logic [BITWIDTH-1:0] req_wdata,
    input  logic                req_ready,
    input  logic [BITWIDTH-1:0] rsp_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WS = CW'(WAIT_STATES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DECODE, WRITE_WAIT, REQ, ACK, HOLD} state_t;

    state_t state, state_d;
    logic [1:0] as_s, ds_s, rw_s;
    logic as, ds, rw;
    logic [CW-1:0] cnt, cnt_d;
    logic addr_oe_d, data_oe_d, data_dir_d, demux_oe_d, ack_n_d, err_n_d, valid_d, write_d;
    logic [BITWIDTH-1:0] addr_d, wdata_d, to_bus_d;

    assign as = as_s[1];
    assign ds = ds_s[1];
    assign rw = rw_s[1];
    assign send_receive = 1'b0;

    always_comb begin
        state_d = state;
        cnt_d = '0;
        addr_oe_d = 1'b0;
        data_oe_d = 1'b0;
        data_dir_d = 1'b0;
        demux_oe_d = 1'b0;
        ack_n_d = 1'b1;
        err_n_d = 1'b1;
        valid_d = 1'b0;
        write_d = req_write;
        addr_d = req_addr;
        wdata_d = req_wdata;
        to_bus_d = to_bus;
        case (state)
            IDLE: begin
                if (!as) begin
                    state_d = ADDR;
                    addr_oe_d = 1'b1;
                end
            end
            ADDR: begin
                addr_d = from_bus;
                state_d = as ? IDLE : DECODE;
            end
            DECODE: begin
                if (as) state_d = IDLE;
                else if ((req_addr & ADDR_MASK) != BASE_ADDR) state_d = HOLD;
                else if (rw) begin
                    state_d = REQ;
                    valid_d = 1'b1;
                    write_d = 1'b0;
                    data_oe_d = 1'b1;
                    data_dir_d = 1'b1;
                end else begin
                    state_d = WRITE_WAIT;
                    data_oe_d = 1'b1;
                end
            end
            WRITE_WAIT: begin
                if (as) state_d = IDLE;
                else if (!ds) begin
                    state_d = REQ;
                    wdata_d = from_bus;
                    valid_d = 1'b1;
                    write_d = 1'b1;
                end else data_oe_d = 1'b1;
            end
            REQ: begin
                if (as) state_d = IDLE;
                else if (req_ready && cnt >= WS) begin
                    state_d = ACK;
                    ack_n_d = 1'b0;
                    to_bus_d = req_write ? to_bus : rsp_rdata;
                    {demux_oe_d, data_oe_d, data_dir_d} = {3{!req_write}};
                end else if (cnt == TO_LAST) begin
                    state_d = ACK;
                    err_n_d = 1'b0;
                    {demux_oe_d, data_oe_d, data_dir_d} = {3{!req_write}};
                end else begin
                    cnt_d = cnt + CW'(1);
                    valid_d = 1'b1;
                    data_oe_d = !req_write;
                    data_dir_d = !req_write;
                end
            end
            ACK: begin
                if (as) state_d = IDLE;
                else begin
                    ack_n_d = data_ack_n;
                    err_n_d = bus_err_n;
                    demux_oe_d = demux_oe;
                    data_oe_d = data_oe;
                    data_dir_d = data_dir;
                end
            end
            HOLD: state_d = as ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            as_s <= 2'b11;
            ds_s <= 2'b11;
            rw_s <= 2'b11;
            state <= IDLE;
            cnt <= '0;
            addr_oe <= 1'b0;
            data_oe <= 1'b0;
            data_dir <= 1'b0;
            demux_oe <= 1'b0;
            data_ack_n <= 1'b1;
            bus_err_n <= 1'b1;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr <= '0;
            req_wdata <= '0;
            to_bus <= '0;
        end else begin
            as_s <= {as_s[0], addr_strobe};
            ds_s <= {ds_s[0], data_strobe};
            rw_s <= {rw_s[0], read_write};
            state <= state_d;
            cnt <= cnt_d;
            addr_oe <= addr_oe_d;
            data_oe <= data_oe_d;
            data_dir <= data_dir_d;
            demux_oe <= demux_oe_d;
            data_ack_n <= ack_n_d;
            bus_err_n <= err_n_d;
            req_valid <= valid_d;
            req_write <= write_d;
            req_addr <= addr_d;
            req_wdata <= wdata_d;
            to_bus <= to_bus_d;
        end
    end
endmodule

// File: tb/tb_computie_bus_target.sv
// tb_computie_bus_target: bus-level transactions checked against a wait-state/timeout reference model.
module tb_computie_bus_target;
    localparam int WS = 3;
    localparam int TO = 64;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam logic [31:0] MASK = 32'hFFF0_0000;

    logic clk, reset_n, addr_strobe, data_strobe, read_write, req_ready;
    logic [31:0] from_bus, rsp_rdata, to_bus, req_addr, req_wdata;
    logic demux_oe, addr_oe, data_oe, data_dir, send_receive, data_ack_n, bus_err_n, req_valid, req_write;
    int compared = 0;
    int mismatched = 0;

    computie_bus_target #(
        .BITWIDTH(32), .BASE_ADDR(BASE), .ADDR_MASK(MASK), .WAIT_STATES(WS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .addr_strobe(addr_strobe), .data_strobe(data_strobe),
        .read_write(read_write), .from_bus(from_bus), .to_bus(to_bus), .demux_oe(demux_oe),
        .addr_oe(addr_oe), .data_oe(data_oe), .data_dir(data_dir), .send_receive(send_receive),
        .data_ack_n(data_ack_n), .bus_err_n(bus_err_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_rdata(rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_valid"}, 32'(req_valid), 0);
        chk({tag, "_demux_oe"}, 32'(demux_oe), 0);
        chk({tag, "_addr_oe"}, 32'(addr_oe), 0);
        chk({tag, "_data_oe"}, 32'(data_oe), 0);
        chk({tag, "_data_dir"}, 32'(data_dir), 0);
        chk({tag, "_send_receive"}, 32'(send_receive), 0);
        chk({tag, "_data_ack_n"}, 32'(data_ack_n), 1);
        chk({tag, "_bus_err_n"}, 32'(bus_err_n), 1);
        chk({tag, "_to_bus"}, to_bus, 0);
        chk({tag, "_req_addr"}, req_addr, 0);
        chk({tag, "_req_wdata"}, req_wdata, 0);
    endtask

    // d: device answers ready from the d-th request cycle on (-1 = ready tied high)
    // abort_after: >=0 releases addr_strobe once that many request cycles were seen
    task automatic txn(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                       input logic [31:0] rdat, input int d, input int abort_after);
        bit match, exp_err;
        int acc, exp_len;
        int vcyc, pulses, ack_cyc, err_cyc, oe_cyc, demux_cyc, first_ack, first_err, last_valid, rel, done;
        logic prev_v;
        match = (a & MASK) == BASE;
        acc = (d > WS) ? d : WS;
        exp_err = acc >= TO;
        exp_len = exp_err ? TO : acc + 1;
        vcyc = 0; pulses = 0; ack_cyc = 0; err_cyc = 0; oe_cyc = 0; demux_cyc = 0;
        first_ack = -1; first_err = -1; last_valid = -1; rel = -1; done = 0; prev_v = 1'b0;
        from_bus = a;
        read_write = rd;
        rsp_rdata = rdat;
        data_strobe = 1'b1;
        addr_strobe = 1'b0;
        for (int c = 0; c < 300 && done == 0; c++) begin
            @(negedge clk);
            if (req_valid) begin
                vcyc++;
                last_valid = c;
                if (!prev_v) pulses++;
            end
            prev_v = req_valid;
            req_ready = (d < 0) || (req_valid && vcyc - 1 >= d);
            if (data_oe) oe_cyc++;
            if (!data_ack_n) begin
                ack_cyc++;
                if (first_ack < 0) first_ack = c;
                if (demux_oe) demux_cyc++;
            end
            if (!bus_err_n) begin
                err_cyc++;
                if (first_err < 0) first_err = c;
            end
            if (!rd && data_oe && rel < 0) begin
                from_bus = wd;
                data_strobe = 1'b0;
            end
            if (rel < 0 && ((first_ack >= 0 && c >= first_ack + 2) || (first_err >= 0 && c >= first_err + 2) ||
                            (!match && c >= 12) || (abort_after >= 0 && vcyc > abort_after))) begin
                rel = c;
                addr_strobe = 1'b1;
                data_strobe = 1'b1;
            end
            if (rel >= 0 && c == rel + 3) done = 1;
        end
        chk("bound", done, 1);
        chk("req_addr", req_addr, a);
        chk("idle_valid", 32'(req_valid), 0);
        chk("idle_ack", 32'(data_ack_n), 1);
        chk("idle_err", 32'(bus_err_n), 1);
        chk("idle_oe", 32'({data_oe, addr_oe, demux_oe}), 0);
        if (!match) begin
            chk("hold_pulses", pulses, 0);
            chk("hold_ack", ack_cyc, 0);
            chk("hold_err", err_cyc, 0);
            chk("hold_data_oe", oe_cyc, 0);
        end else if (abort_after >= 0) begin
            chk("abort_pulses", pulses, 1);
            chk("abort_ack", ack_cyc + err_cyc, 0);
            chk("abort_drop", last_valid, rel + 2);
        end else begin
            chk("pulses", pulses, 1);
            chk("req_len", vcyc, exp_len);
            chk("req_write", 32'(req_write), 32'(!rd));
            if (!rd) chk("req_wdata", req_wdata, wd);
            if (exp_err) begin
                chk("err_at", first_err, last_valid + 1);
                chk("err_hold", err_cyc, rel + 3 - first_err);
                chk("err_no_ack", ack_cyc, 0);
            end else begin
                chk("ack_at", first_ack, last_valid + 1);
                chk("ack_hold", ack_cyc, rel + 3 - first_ack);
                chk("ack_no_err", err_cyc, 0);
                if (rd) begin
                    chk("to_bus", to_bus, rdat);
                    chk("demux_oe", demux_cyc, ack_cyc);
                end
            end
        end
        req_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0;
        addr_strobe = 1'b1;
        data_strobe = 1'b1;
        read_write = 1'b1;
        from_bus = '0;
        req_ready = 1'b0;
        rsp_rdata = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);
        txn(32'h0010_0040, 1'b0, 32'hDEADBEEF, 32'h0, -1, -1);
        txn(32'h0010_0004, 1'b1, 32'h0, 32'h1234_5678, 0, -1);
        txn(32'h0010_0008, 1'b1, 32'h0, 32'h0BAD_F00D, 6, -1);
        txn(32'h0020_0000, 1'b1, 32'h0, 32'h1, 0, -1);
        txn(32'h0020_0000, 1'b0, 32'h5, 32'h0, 0, -1);
        txn(32'h0010_0100, 1'b1, 32'h0, 32'hAAAA_5555, 200, -1);
        txn(32'h0010_0200, 1'b0, 32'h7777_1111, 32'h0, 63, -1);
        txn(32'h0010_000C, 1'b1, 32'h0, 32'h0, 200, 2);
        for (int i = 0; i < 40; i++) begin
            int r, d, ab;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 3) == 0) ? $urandom() : (BASE | ($urandom() & ~MASK));
            d = (r < 6) ? int'($urandom_range(0, 6)) : (r == 6) ? -1 : (r == 7) ? 64 + int'($urandom_range(0, 5)) : 200;
            ab = (r >= 8) ? int'($urandom_range(0, 4)) : -1;
            txn(a, 1'($urandom_range(0, 1)), $urandom(), $urandom(), d, ab);
        end
        txn(32'h0010_0020, 1'b1, 32'h0, 32'hCAFE_F00D, 0, -1);
        from_bus = 32'h0010_0010;
        read_write = 1'b1;
        req_ready = 1'b0;
        addr_strobe = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = req_valid;
        end
        chk("rst_reach_req", 32'(seen), 1);
        #2 reset_n = 1'b0;
        #1 check_reset("rst_async");
        addr_strobe = 1'b1;
        @(negedge clk);
        check_reset("rst_held");
        reset_n = 1'b1;
        @(negedge clk);
        txn(32'h0010_0044, 1'b0, 32'h0102_0304, 32'h0, 1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/computie_bus_target.md
COMPUTIE_BUS_TARGET -- requirements
Module: computie_bus_target

Interface
REQ-001 The module SHALL have parameter BITWIDTH, default 32, giving the multiplexed bus, address and data width.
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h0010_0000, giving the decode match value.
REQ-003 The module SHALL have parameter ADDR_MASK, default 32'hFFF0_0000, giving the decode compare mask.
REQ-004 The module SHALL have parameter WAIT_STATES, default 0, giving the minimum request cycles before acknowledge; range 0..15.
REQ-005 The module SHALL have parameter TIMEOUT, default 64, giving the device-stall cycles before bus error; TIMEOUT > WAIT_STATES.
REQ-006 The module SHALL have the following ports, one per line: name, direction, width, meaning:
 clk  in  1  single clock, rising edge
 reset_n  in  1  asynchronous, active-low reset
 addr_strobe  in  1  bus address strobe, active low, asynchronous to clk
 data_strobe  in  1  bus data strobe, active low, asynchronous to clk
 read_write  in  1  bus direction, 1 = bus reads from device
 from_bus  in  BITWIDTH  demuxed bus value, address phase then data phase
 to_bus  out  BITWIDTH  read data presented to bus
 demux_oe  out  1  enables to_bus onto bus
 addr_oe  out  1  address transceiver enable
 data_oe  out  1  data transceiver enable
 data_dir  out  1  data transceiver direction, 1 = device to bus
 send_receive  out  1  control transceiver direction, constant 0 (receive)
 data_ack_n  out  1  transfer acknowledge to bus, active low
 bus_err_n  out  1  bus error to bus, active low
 req_valid  out  1  internal request to device
 req_write  out  1  1 = write request
 req_addr  out  BITWIDTH  latched address
 req_wdata  out  BITWIDTH  latched write data
 req_ready  in  1  device completes request
 rsp_rdata  in  BITWIDTH  device read data, valid with req_ready

Function
REQ-007 The block SHALL pass addr_strobe, data_strobe and read_write through 2-flop synchronizers (reset to 1,1,1); all decisions SHALL use synchronized values.
REQ-008 The FSM SHALL have states IDLE, ADDR, DECODE, WRITE_WAIT, REQ, ACK, HOLD; all outputs registered.
- IDLE: all enables 0, data_ack_n=1, bus_err_n=1; synced addr_strobe low -> ADDR.
- ADDR: addr_oe=1; req_addr <= from_bus at end of cycle; -> DECODE.
- DECODE: addr_oe=0; (req_addr & ADDR_MASK)==BASE_ADDR -> REQ if read, WRITE_WAIT if write; no match -> HOLD.
- WRITE_WAIT: data_oe=1, data_dir=0; when synced data_strobe low, req_wdata <= from_bus -> REQ.
- REQ: req_valid=1, req_write=!read_write; read: data_oe=1, data_dir=1; counter counts cycles from entry.
- ACK: data_ack_n=0 (or bus_err_n=0 on timeout); held until synced addr_strobe high -> IDLE.
- HOLD: no outputs driven; synced addr_strobe high -> IDLE.
REQ-009 REQ SHALL exit to ACK only when req_ready=1 AND counter >= WAIT_STATES; req_ready is sampled only in REQ.
REQ-010 On a read, rsp_rdata SHALL be latched into to_bus when req_ready is seen, and demux_oe SHALL be 1 in ACK.
REQ-011 req_valid SHALL drop the cycle after req_ready is accepted; req_ready in the first REQ cycle SHALL be accepted (zero device latency).
REQ-012 If the counter reaches TIMEOUT in REQ without acceptance, the FSM SHALL enter ACK with bus_err_n=0 and data_ack_n=1.
REQ-013 Synced addr_strobe high in ADDR, DECODE, WRITE_WAIT or REQ SHALL abort to IDLE: req_valid and all enables 0 next cycle; no acknowledge.
REQ-014 req_addr, req_wdata and to_bus SHALL hold their values until next overwritten.

Reset
REQ-015 While reset_n=0: state IDLE, req_valid, demux_oe, addr_oe, data_oe, data_dir, send_receive = 0; data_ack_n and bus_err_n = 1; to_bus, req_addr, req_wdata, counter = 0.
REQ-016 Reset assertion mid-transaction SHALL release all bus drivers immediately (asynchronously).

Verification
REQ-017 Write 0x0010_0040 <= 0xDEADBEEF, req_ready tied 1 -> one req_valid pulse, req_write=1, req_wdata=0xDEADBEEF, data_ack_n low until addr_strobe high.
REQ-018 Read 0x0010_0004, rsp_rdata=0x12345678, WAIT_STATES=3 -> data_ack_n falls no earlier than 3 REQ cycles; to_bus=0x12345678, demux_oe=1.
REQ-019 Access 0x0020_0000 -> HOLD; req_valid, data_oe, data_ack_n, bus_err_n never asserted.
REQ-020 Read with req_ready held 0, TIMEOUT=64 -> bus_err_n=0 after 64 REQ cycles, data_ack_n stays 1.
REQ-021 addr_strobe released during REQ -> IDLE, req_valid=0 next cycle; reset_n pulsed mid-read -> all outputs at REQ-015 values.
